// File: rtl/multi_channel_incrementer_pkg.sv
// Shared definitions for the multi-channel incrementer: command opcodes,
// result flag layout and the derived channel-index width.
package multi_channel_incrementer_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_CHANNELS = 4;

    typedef enum logic [1:0] {
        OP_INC  = 2'd0,
        OP_DEC  = 2'd1,
        OP_LOAD = 2'd2,
        OP_READ = 2'd3
    } op_e;

    typedef struct packed {
        logic ovf;
        logic err;
    } res_flags_t;

    // A single-channel bank still needs a one-bit index.
    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/multi_channel_incrementer_if.sv
// Command and result streams of the multi-channel incrementer, both
// valid/ready handshaked.
interface multi_channel_incrementer_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    import multi_channel_incrementer_pkg::*;

    localparam int CHAN_W = chan_width(CHANNELS);

    logic              cmd_valid;
    logic              cmd_ready;
    op_e               cmd_op;
    logic              cmd_sat;
    logic [CHAN_W-1:0] cmd_chan;
    logic [WIDTH-1:0]  cmd_data;

    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  res_value;
    logic [CHAN_W-1:0] res_chan;
    logic              res_ovf;
    logic              res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_sat, cmd_chan, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_value, res_chan, res_ovf, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sat, cmd_chan, cmd_data, res_ready,
        output cmd_ready, res_valid, res_value, res_chan, res_ovf, res_err
    );

endinterface

// File: rtl/multi_channel_incrementer_alu.sv
// Combinational counter update: wrap or saturating add/subtract of a step,
// plus load and pass-through, with carry/borrow/clamp reporting.
module incrementer_alu
    import multi_channel_incrementer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_step,
    input  op_e              i_op,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_value,
    output logic             o_ovf
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // The extra top bit carries out on add and borrows on subtract.
    assign w_sum  = {1'b0, i_cnt} + {1'b0, i_step};
    assign w_diff = {1'b0, i_cnt} - {1'b0, i_step};

    always_comb begin
        o_value = i_cnt;
        o_ovf   = 1'b0;
        unique case (i_op)
            OP_INC: begin
                o_ovf   = w_sum[WIDTH];
                o_value = (i_sat && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
            end
            OP_DEC: begin
                o_ovf   = w_diff[WIDTH];
                o_value = (i_sat && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
            end
            OP_LOAD: begin
                o_value = i_step;
            end
            OP_READ: begin
                o_value = i_cnt;
            end
            default: begin
                o_value = i_cnt;
            end
        endcase
    end

endmodule

// File: rtl/multi_channel_incrementer.sv
// Bank of independent counters updated by a command stream; every accepted
// command produces one result beat through a single back-pressurable register.
module multi_channel_incrementer
    import multi_channel_incrementer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS
) (
    input logic                      clk,
    input logic                      rst,
    multi_channel_incrementer_if.slave bus
);

    localparam int CHAN_W = chan_width(CHANNELS);

    logic [WIDTH-1:0]  r_cnt [CHANNELS];
    logic              r_res_valid;
    logic [WIDTH-1:0]  r_res_value;
    logic [CHAN_W-1:0] r_res_chan;
    res_flags_t        r_res_flags;

    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_chan_ok;
    logic [WIDTH-1:0]  w_cur;
    logic [WIDTH-1:0]  w_alu_value;
    logic              w_alu_ovf;

    assign w_cmd_ready = !rst && (!r_res_valid || bus.res_ready);
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_chan_ok   = ({1'b0, bus.cmd_chan} < (CHAN_W + 1)'(CHANNELS));

    // Out-of-range channels read as zero so the ALU never sees stale data.
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.cmd_chan == CHAN_W'(i)) begin
                w_cur = r_cnt[i];
            end
        end
    end

    incrementer_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .i_cnt  (w_cur),
        .i_step (bus.cmd_data),
        .i_op   (bus.cmd_op),
        .i_sat  (bus.cmd_sat),
        .o_value(w_alu_value),
        .o_ovf  (w_alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_accept && w_chan_ok && (bus.cmd_chan == CHAN_W'(i))) begin
                    r_cnt[i] <= w_alu_value;
                end
            end
        end
    end

    // Result register only changes on accept or drain, so it holds steady
    // while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_value <= '0;
            r_res_chan  <= '0;
            r_res_flags <= '0;
        end else if (w_accept) begin
            r_res_valid     <= 1'b1;
            r_res_value     <= w_chan_ok ? w_alu_value : '0;
            r_res_chan      <= bus.cmd_chan;
            r_res_flags.ovf <= w_chan_ok && w_alu_ovf;
            r_res_flags.err <= !w_chan_ok;
        end else if (r_res_valid && bus.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_value = r_res_value;
    assign bus.res_chan  = r_res_chan;
    assign bus.res_ovf   = r_res_flags.ovf;
    assign bus.res_err   = r_res_flags.err;

endmodule

// File: tb/tb_multi_channel_incrementer.sv
// Scoreboard bench: drivers push model predictions into queues, monitors pop
// and compare whenever a result beat is presented (4- and 3-channel builds).
module tb_multi_channel_incrementer;
    import multi_channel_incrementer_pkg::*;

    localparam int MAXV   = 255;
    localparam int BUDGET = 200;

    typedef struct {
        int value;
        int chan;
        int ovf;
        int err;
    } exp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst3 = 1'b1;

    int   vectors     = 0;
    int   miscompares = 0;
    int   readyMode   = 1;
    int   cycleCount  = 0;
    bit   done3       = 1'b0;
    int   model4 [4];
    int   model3 [3];
    exp_t q4 [$];
    exp_t q3 [$];

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    multi_channel_incrementer_if #(.WIDTH(8), .CHANNELS(4)) if4 ();
    multi_channel_incrementer_if #(.WIDTH(8), .CHANNELS(3)) if3 ();

    multi_channel_incrementer #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk(clk),
        .rst(rst),
        .bus(if4)
    );

    multi_channel_incrementer #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk),
        .rst(rst3),
        .bus(if3)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Specification-level arithmetic on plain integers.
    function automatic void refModel(input int op, input int sat, input int cur, input int step,
                                     output int nv, output int ovf);
        int t;
        nv  = cur;
        ovf = 0;
        case (op)
            0: begin
                t   = cur + step;
                ovf = (t > MAXV) ? 1 : 0;
                nv  = (t > MAXV) ? ((sat != 0) ? MAXV : t - (MAXV + 1)) : t;
            end
            1: begin
                t   = cur - step;
                ovf = (t < 0) ? 1 : 0;
                nv  = (t < 0) ? ((sat != 0) ? 0 : t + (MAXV + 1)) : t;
            end
            2: nv = step;
            default: nv = cur;
        endcase
    endfunction

    task automatic applyStimulus(input int op, input int sat, input int chan, input int data);
        exp_t e;
        int   nv;
        int   ov;
        bit   taken;
        taken = 1'b0;
        @(negedge clk);
        if4.cmd_valid = 1'b1;
        if4.cmd_op    = op_e'(op[1:0]);
        if4.cmd_sat   = sat[0];
        if4.cmd_chan  = chan[1:0];
        if4.cmd_data  = data[7:0];
        for (int n = 0; n < BUDGET && !taken; n++) begin
            #2;
            if (if4.cmd_ready) taken = 1'b1;
            else @(negedge clk);
        end
        if (!taken) begin
            checkOutput("cmdAcceptTimeout4", 0, 1);
            if4.cmd_valid = 1'b0;
            return;
        end
        refModel(op, sat, model4[chan], data, nv, ov);
        model4[chan] = nv;
        e = '{nv, chan, ov, 0};
        q4.push_back(e);
        @(posedge clk);
        #1;
        if4.cmd_valid = 1'b0;
    endtask

    task automatic applyStimulus3(input int op, input int sat, input int chan, input int data);
        exp_t e;
        int   nv;
        int   ov;
        bit   taken;
        taken = 1'b0;
        @(negedge clk);
        if3.cmd_valid = 1'b1;
        if3.cmd_op    = op_e'(op[1:0]);
        if3.cmd_sat   = sat[0];
        if3.cmd_chan  = chan[1:0];
        if3.cmd_data  = data[7:0];
        for (int n = 0; n < BUDGET && !taken; n++) begin
            #2;
            if (if3.cmd_ready) taken = 1'b1;
            else @(negedge clk);
        end
        if (!taken) begin
            checkOutput("cmdAcceptTimeout3", 0, 1);
            if3.cmd_valid = 1'b0;
            return;
        end
        if (chan >= 3) begin
            e = '{0, chan, 0, 1};
        end else begin
            refModel(op, sat, model3[chan], data, nv, ov);
            model3[chan] = nv;
            e = '{nv, chan, ov, 0};
        end
        q3.push_back(e);
        @(posedge clk);
        #1;
        if3.cmd_valid = 1'b0;
    endtask

    task automatic waitDrain4();
        for (int n = 0; n < BUDGET && q4.size() != 0; n++) @(negedge clk);
        if (q4.size() != 0) checkOutput("drainTimeout4", q4.size(), 0);
    endtask

    // Monitor for the 4-channel build; also re-checks held beats while stalled.
    initial begin
        exp_t e;
        if4.res_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       if4.res_ready = 1'b0;
                1:       if4.res_ready = 1'b1;
                default: if4.res_ready = ($urandom_range(0, 1) == 1);
            endcase
            #3;
            if (!rst && if4.res_valid) begin
                if (q4.size() == 0) begin
                    checkOutput("unexpectedResult4", 1, 0);
                end else begin
                    e = q4[0];
                    checkOutput("resValue4", int'(if4.res_value), e.value);
                    checkOutput("resChan4", int'(if4.res_chan), e.chan);
                    checkOutput("resOvf4", int'(if4.res_ovf), e.ovf);
                    checkOutput("resErr4", int'(if4.res_err), e.err);
                    if (if4.res_ready) void'(q4.pop_front());
                end
            end
        end
    end

    initial begin
        exp_t e;
        if3.res_ready = 1'b1;
        forever begin
            @(negedge clk);
            #3;
            if (!rst3 && if3.res_valid) begin
                if (q3.size() == 0) begin
                    checkOutput("unexpectedResult3", 1, 0);
                end else begin
                    e = q3.pop_front();
                    checkOutput("resValue3", int'(if3.res_value), e.value);
                    checkOutput("resChan3", int'(if3.res_chan), e.chan);
                    checkOutput("resOvf3", int'(if3.res_ovf), e.ovf);
                    checkOutput("resErr3", int'(if3.res_err), e.err);
                end
            end
        end
    end

    // Three-channel build: out-of-range index must not touch any counter.
    initial begin
        if3.cmd_valid = 1'b0;
        if3.cmd_op    = OP_READ;
        if3.cmd_sat   = 1'b0;
        if3.cmd_chan  = '0;
        if3.cmd_data  = '0;
        for (int i = 0; i < 3; i++) model3[i] = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst3 = 1'b0;
        applyStimulus3(2, 0, 0, 8'h11);
        applyStimulus3(2, 0, 1, 8'h22);
        applyStimulus3(2, 0, 2, 8'h33);
        applyStimulus3(0, 1, 3, 5);
        applyStimulus3(1, 0, 3, 9);
        applyStimulus3(2, 0, 3, 8'h77);
        applyStimulus3(3, 0, 3, 0);
        for (int c = 0; c < 3; c++) applyStimulus3(3, 0, c, 0);
        for (int n = 0; n < BUDGET && q3.size() != 0; n++) @(negedge clk);
        if (q3.size() != 0) checkOutput("drainTimeout3", q3.size(), 0);
        done3 = 1'b1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int start;
        int r;
        int dat;
        if4.cmd_valid = 1'b0;
        if4.cmd_op    = OP_READ;
        if4.cmd_sat   = 1'b0;
        if4.cmd_chan  = '0;
        if4.cmd_data  = '0;
        for (int i = 0; i < 4; i++) model4[i] = 0;

        @(negedge clk);
        #2;
        checkOutput("cmdReadyInReset", int'(if4.cmd_ready), 0);
        @(negedge clk);
        #2;
        checkOutput("resetResValid", int'(if4.res_valid), 0);
        checkOutput("resetResValue", int'(if4.res_value), 0);
        checkOutput("resetResChan", int'(if4.res_chan), 0);
        checkOutput("resetResOvf", int'(if4.res_ovf), 0);
        checkOutput("resetResErr", int'(if4.res_err), 0);
        rst = 1'b0;

        readyMode = 1;
        for (int c = 0; c < 4; c++) applyStimulus(3, 0, c, 0);

        applyStimulus(2, 0, 1, 8'hFE);
        applyStimulus(0, 0, 1, 3);
        applyStimulus(2, 0, 1, 8'hFE);
        applyStimulus(0, 1, 1, 3);
        applyStimulus(2, 0, 2, 8'h05);
        applyStimulus(1, 1, 2, 7);
        applyStimulus(2, 0, 2, 8'h05);
        applyStimulus(1, 0, 2, 7);
        applyStimulus(0, 0, 2, 0);

        // Stall the consumer with a command waiting.
        readyMode = 0;
        fork
            applyStimulus(0, 0, 3, 1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    #2;
                    checkOutput("cmdReadyStalled", int'(if4.cmd_ready), 0);
                end
                readyMode = 1;
            end
        join

        applyStimulus(2, 0, 0, 0);
        start = cycleCount;
        repeat (4) applyStimulus(0, 0, 0, 1);
        checkOutput("throughputCycles", cycleCount - start, 4);

        readyMode = 2;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 7);
            dat = (r == 0) ? 0 : (r == 1) ? MAXV : $urandom_range(0, MAXV);
            if ($urandom_range(0, 3) == 0) @(posedge clk);
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), dat);
        end
        readyMode = 1;
        waitDrain4();

        // Reset while a result is held and counters are non-zero.
        applyStimulus(2, 0, 1, 8'h44);
        @(negedge clk);
        #2;
        readyMode = 0;
        applyStimulus(2, 0, 0, 8'h33);
        repeat (2) @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        readyMode = 1;
        q4.delete();
        for (int i = 0; i < 4; i++) model4[i] = 0;
        @(negedge clk);
        #2;
        checkOutput("cmdReadyInReset2", int'(if4.cmd_ready), 0);
        checkOutput("resValidAfterReset", int'(if4.res_valid), 0);
        checkOutput("resValueAfterReset", int'(if4.res_value), 0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) applyStimulus(3, 0, c, 0);
        waitDrain4();

        for (int n = 0; n < BUDGET && !done3; n++) @(negedge clk);
        if (!done3) checkOutput("dut3Timeout", 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
